// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes and registered result, zero, branch decision.
// Optional feature macro ALU_SERIAL_SHIFT_EN: shifts run one bit per cycle instead of a barrel shifter.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLT  = 4'h5,
    ALU_SLTU = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9
  } alu_op_t;
endpackage

module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_control,
  input  logic              branch_condition,
  input  logic              is_branch,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              branch_taken,
  output logic              illegal_op,
  output logic              busy
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic [SH_W-1:0]   sh_amt;
  logic [DATA_W-1:0] alu_res;
  logic              alu_illegal;
  logic              alu_lt_s, alu_lt_u;

  logic              wr_en;
  logic [DATA_W-1:0] wr_result;
  logic              wr_illegal;
  logic              wr_is_branch;
  logic              wr_bcond;
  logic              wr_zero;

  assign in_ready = !reset && (state_q == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sh_amt   = op_b[SH_W-1:0];
  assign alu_lt_s = $signed(op_a) < $signed(op_b);
  assign alu_lt_u = op_a < op_b;

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (alu_control)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, alu_lt_s};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, alu_lt_u};
`ifdef ALU_SERIAL_SHIFT_EN
      // Only shift-by-zero completes here; nonzero amounts go through the serial path.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
`else
      ALU_SLL:  alu_res = op_a << sh_amt;
      ALU_SRL:  alu_res = op_a >> sh_amt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> sh_amt);
`endif
      default:  alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_SERIAL_SHIFT_EN
  logic [DATA_W-1:0] sh_val_q;
  logic [DATA_W-1:0] sh_step;
  logic [SH_W-1:0]   sh_cnt_q;
  alu_op_t           sh_kind_q;
  logic              sh_br_q, sh_bc_q;
  logic              is_shift;
  logic              start_shift;
  logic              shift_done;

  assign is_shift    = (alu_control == ALU_SLL) || (alu_control == ALU_SRL) ||
                       (alu_control == ALU_SRA);
  assign start_shift = accept && is_shift && (sh_amt != '0);
  assign shift_done  = (state_q == SHIFT) && (sh_cnt_q == SH_W'(1));
  assign busy        = (state_q == SHIFT);

  always_comb begin
    sh_step = sh_val_q;
    case (sh_kind_q)
      ALU_SLL: sh_step = {sh_val_q[DATA_W-2:0], 1'b0};
      ALU_SRL: sh_step = {1'b0, sh_val_q[DATA_W-1:1]};
      default: sh_step = {sh_val_q[DATA_W-1], sh_val_q[DATA_W-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_shift) state_d = SHIFT;
      SHIFT:   if (shift_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_val_q  <= '0;
      sh_cnt_q  <= '0;
      sh_kind_q <= ALU_SLL;
      sh_br_q   <= 1'b0;
      sh_bc_q   <= 1'b0;
    end else if (start_shift) begin
      sh_val_q  <= op_a;
      sh_cnt_q  <= sh_amt;
      sh_kind_q <= alu_op_t'(alu_control);
      sh_br_q   <= is_branch;
      sh_bc_q   <= branch_condition;
    end else if (state_q == SHIFT) begin
      sh_val_q  <= sh_step;
      sh_cnt_q  <= sh_cnt_q - SH_W'(1);
    end
  end

  always_comb begin
    wr_en        = accept && !start_shift;
    wr_result    = alu_illegal ? '0 : alu_res;
    wr_illegal   = alu_illegal;
    wr_is_branch = is_branch;
    wr_bcond     = branch_condition;
    if (shift_done) begin
      wr_en        = 1'b1;
      wr_result    = sh_step;
      wr_illegal   = 1'b0;
      wr_is_branch = sh_br_q;
      wr_bcond     = sh_bc_q;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    state_d = IDLE;
  end

  always_comb begin
    wr_en        = accept;
    wr_result    = alu_illegal ? '0 : alu_res;
    wr_illegal   = alu_illegal;
    wr_is_branch = is_branch;
    wr_bcond     = branch_condition;
  end
`endif

  assign wr_zero = (wr_result == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      result       <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
    end else if (wr_en) begin
      out_valid    <= 1'b1;
      result       <= wr_result;
      zero         <= wr_zero;
      branch_taken <= wr_is_branch && !wr_illegal && (wr_zero == wr_bcond);
      illegal_op   <= wr_illegal;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors for alu_exec_unit; latency expectations follow ALU_SERIAL_SHIFT_EN.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic        branch_condition;
  logic        is_branch;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        branch_taken;
  logic        illegal_op;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu_exec_unit #(.DATA_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .alu_control      (alu_control),
    .branch_condition (branch_condition),
    .is_branch        (is_branch),
    .op_a             (op_a),
    .op_b             (op_b),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .zero             (zero),
    .branch_taken     (branch_taken),
    .illegal_op       (illegal_op),
    .busy             (busy)
  );

  always #5 clk = ~clk;

`ifdef ALU_SERIAL_SHIFT_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one op at a negedge and returns just after the accepting posedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic br, input logic bc);
    int unsigned waited = 0;
    @(negedge clk);
    alu_control = op; op_a = a; op_b = b; is_branch = br; branch_condition = bc;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic br, input logic bc,
                        input logic [31:0] exp_res, input logic exp_zero,
                        input logic exp_bt, input logic exp_ill, input int unsigned exp_lat);
    int unsigned lat = 0;
    issue(op, a, b, br, bc);
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) begin
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_inrdy"}, 64'(in_ready), 64'd0);
      end
    end while (!out_valid && lat < 64);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_zero"}, 64'(zero), 64'(exp_zero));
    check({tag, "_bt"}, 64'(branch_taken), 64'(exp_bt));
    check({tag, "_ill"}, 64'(illegal_op), 64'(exp_ill));
  endtask

  initial begin
    int unsigned seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = '0; op_a = '0; op_b = '0; is_branch = 1'b0; branch_condition = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_inrdy", 64'(in_ready), 64'd0);
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_res", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ill", 64'(illegal_op), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_inrdy", 64'(in_ready), 64'd1);

    run_op("add_ovf",  ALU_ADD,  32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 0, 0, 1);
    run_op("beq_t",    ALU_SUB,  32'd5, 32'd5, 1, 1, 32'h0, 1, 1, 0, 1);
    run_op("bne_nt",   ALU_SUB,  32'd5, 32'd5, 1, 0, 32'h0, 1, 0, 0, 1);
    run_op("nobr",     ALU_SUB,  32'd5, 32'd5, 0, 1, 32'h0, 1, 0, 0, 1);
    run_op("sub_wrap", ALU_SUB,  32'h0, 32'h1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 1);
    run_op("blt",      ALU_SLT,  32'hFFFF_FFFF, 32'h1, 1, 0, 32'h1, 0, 1, 0, 1);
    run_op("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 1, 1, 32'h0, 1, 1, 0, 1);
    run_op("and",      ALU_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 32'h00F0_1234, 0, 0, 0, 1);
    run_op("or",       ALU_OR,   32'h1234_0000, 32'h0000_5678, 0, 0, 32'h1234_5678, 0, 0, 0, 1);
    run_op("sra4",     ALU_SRA,  32'h8000_0000, 32'd4, 0, 0, 32'hF800_0000, 0, 0, 0, SERIAL ? 5 : 1);
    run_op("sll0",     ALU_SLL,  32'h1, 32'd0, 0, 0, 32'h1, 0, 0, 0, 1);
    run_op("sll4",     ALU_SLL,  32'h3, 32'h0000_0024, 0, 0, 32'h30, 0, 0, 0, SERIAL ? 5 : 1);
    run_op("srl31",    ALU_SRL,  32'h8000_0000, 32'd31, 0, 0, 32'h1, 0, 0, 0, SERIAL ? 32 : 1);
    run_op("ill_f",    4'hF,     32'h5, 32'h5, 1, 1, 32'h0, 1, 0, 1, 1);
    run_op("ill_a",    4'hA,     32'h9, 32'h3, 0, 0, 32'h0, 1, 0, 1, 1);
    run_op("legal_after_ill", ALU_ADD, 32'h1, 32'h1, 0, 0, 32'h2, 0, 0, 0, 1);

    // Backpressure: result must hold while the consumer stalls.
    @(negedge clk);
    out_ready = 1'b0;
    run_op("xor",      ALU_XOR,  32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 32'hF0F0_F0F0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_res", 64'(result), 64'hF0F0_F0F0);
      check("hold_ovalid", 64'(out_valid), 64'd1);
      check("hold_inrdy", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    alu_control = ALU_ADD; op_a = 32'd1; op_b = 32'd2; is_branch = 1'b0; in_valid = 1'b1;
    #1;
    check("b2b_inrdy", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_ovalid", 64'(out_valid), 64'd1);
    check("b2b_res", 64'(result), 64'd3);
    @(negedge clk);
    check("drain_ovalid", 64'(out_valid), 64'd0);

    // Reset during a long shift.
    issue(ALU_SRL, 32'hFFFF_FFFF, 32'd20, 0, 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    if (SERIAL) check("pre_rst_ovalid", 64'(seen), 64'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_ovalid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_res", 64'(result), 64'd0);
    check("mid_rst_inrdy", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_inrdy", 64'(in_ready), 64'd1);
    check("rel_zero", 64'(zero), 64'd0);
    check("rel_bt", 64'(branch_taken), 64'd0);
    check("rel_ill", 64'(illegal_op), 64'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check("post_abort_quiet", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit operation code and branch_condition bit produced by the ALU control decoder, performs the operation on two DATA_W-bit operands and returns a registered result, zero flag and branch-taken decision. It sits between the decode/issue logic and the writeback/branch-resolution logic, with a valid/ready handshake on both sides so that multi-cycle shifts can stall issue.

## Interface
- DATA_W, 32, operand/result width; power of two, at least 8.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts the operation this cycle.
- alu_control  in  4  operation code, common package enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA).
- branch_condition  in  1  branch polarity bit from the decoder.
- is_branch  in  1  operation is a conditional branch compare.
- op_a, op_b  in  DATA_W  operands; shift amount is op_b[log2(DATA_W)-1:0].
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  DATA_W  operation result.
- zero  out  1  result == 0.
- branch_taken  out  1  resolved branch decision.
- illegal_op  out  1  alu_control matched no enumerator.
- busy  out  1  multi-cycle shift in progress.

## Operation
- Accept when in_valid && in_ready. in_ready = (state == IDLE) && (!out_valid || out_ready); forced 0 while reset is asserted.
- FSM: IDLE, SHIFT. IDLE -> SHIFT on accepting a shift with nonzero amount (serial mode only); SHIFT -> IDLE when the remaining count reaches zero; all other accepts stay in IDLE.
- ADD/SUB wrap modulo 2^DATA_W. SLT signed, SLTU unsigned; result is 0 or 1, zero-extended. AND/OR/XOR bitwise. SLL/SRL fill with 0, SRA with op_a sign bit.
- zero = (result == 0), registered with the result.
- branch_taken = is_branch && (zero == branch_condition); 0 when is_branch is 0. Covers BEQ/BNE (SUB), BLT/BGE (SLT), BLTU/BGEU (SLTU).
- Illegal code (4'hF and any other unassigned value): result 0, zero 1, branch_taken 0, illegal_op 1, single-cycle latency. illegal_op is 0 for legal codes.
- Output registers hold value while out_valid && !out_ready; out_valid clears on out_ready unless a new result is written the same edge.
- Output slot is always free when a shift completes, because accept requires it free.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, zero 0, branch_taken 0, illegal_op 0, busy 0, shift count 0.
- Non-shift ops, and shifts by 0: accepted at edge N, outputs valid from cycle N+1 (latency 1).
- Serial shift by k>0: k cycles in SHIFT, one bit per cycle, busy=1, in_ready=0; outputs valid from cycle N+1+k.
- Back-to-back: accept allowed in the same cycle the previous result is consumed; sustained throughput 1 op/cycle for single-cycle ops.
- Reset mid-shift: aborts immediately, no result produced, out_valid stays 0.

## Configuration
- ALU_SERIAL_SHIFT_EN defined: shifts executed serially as above (area-reduced).
- Not defined: single-cycle barrel shifter, SHIFT state unreachable, busy tied 0, all legal ops have latency 1.

## Test plan
- ADD op_a=0x7FFFFFFF, op_b=1 -> result 0x80000000, zero 0, out_valid one cycle after accept.
- SUB 5,5, is_branch=1, branch_condition=1 -> result 0, zero 1, branch_taken 1; same with branch_condition=0 -> branch_taken 0; SLT -1,1 with branch_condition=0 -> result 1, branch_taken 1.
- With ALU_SERIAL_SHIFT_EN: SRA 0x80000000 by 4 -> 0xF8000000, busy and in_ready=0 for 4 cycles, out_valid 5 cycles after accept; SLL by 0 -> latency 1. Without macro: same result, latency 1.
- Hold out_ready=0 for 3 cycles after XOR 0xFF00FF00^0x0FF00FF0 -> result 0xF0F0F0F0 stable, in_ready 0; raise out_ready with in_valid high -> next op accepted same cycle.
- alu_control=4'hF -> illegal_op 1, result 0, zero 1, branch_taken 0 after 1 cycle.
- SRL 0xFFFFFFFF by 20, assert reset 5 cycles in -> out_valid never rises, all outputs at reset values, in_ready 1 first cycle after release.
